// File: rtl/muldiv_pkg.sv
// Shared constants and helpers for the E-stage multiply/divide unit.
// Codes 4..7 (madd family) are only honoured when MULDIV_MADD_EN is defined.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_e;

    localparam logic [1:0] MV_NONE = 2'd0;
    localparam logic [1:0] MV_HI   = 2'd1;
    localparam logic [1:0] MV_LO   = 2'd2;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;
    localparam int unsigned CNT_W           = 5;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational 64-bit result generator for mult/div and, with MULDIV_MADD_EN,
// the multiply-accumulate family using the current {HI,LO} as the base.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
`ifdef MULDIV_MADD_EN
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
`endif
    output logic        o_legal,
    output logic        o_is_div,
    output logic        o_wr,
    output logic [63:0] o_res
);

    logic signed [63:0] w_sa;
    logic signed [63:0] w_sb;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_mag_a;
    logic        [31:0] w_mag_b;
    logic        [31:0] w_sdiv;
    logic        [31:0] w_udiv;
    logic        [31:0] w_sq;
    logic        [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;
    logic               w_b_zero;
`ifdef MULDIV_MADD_EN
    logic        [63:0] w_base;
    assign w_base = {i_hi, i_lo};
`endif

    assign w_sa     = {{32{i_a[31]}}, i_a};
    assign w_sb     = {{32{i_b[31]}}, i_b};
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide on magnitudes so INT_MIN / -1 wraps to INT_MIN with zero remainder.
    assign w_b_zero = (i_b == 32'd0);
    assign w_mag_a  = abs32(i_a);
    assign w_mag_b  = abs32(i_b);
    assign w_sdiv   = w_b_zero ? 32'd1 : w_mag_b;
    assign w_udiv   = w_b_zero ? 32'd1 : i_b;
    assign w_sq     = w_mag_a / w_sdiv;
    assign w_sr     = w_mag_a % w_sdiv;
    assign w_uq     = i_a / w_udiv;
    assign w_ur     = i_a % w_udiv;

    // Select the result for the issuing opcode.
    always_comb begin
        o_res    = 64'd0;
        o_legal  = 1'b1;
        o_is_div = 1'b0;
        o_wr     = 1'b1;
        case (md_op_e'(i_op))
            MD_MULT:  o_res = w_prod_s;
            MD_MULTU: o_res = w_prod_u;
            MD_DIV: begin
                o_is_div = 1'b1;
                o_wr     = ~w_b_zero;
                o_res    = {(i_a[31] ? (32'd0 - w_sr) : w_sr),
                            ((i_a[31] ^ i_b[31]) ? (32'd0 - w_sq) : w_sq)};
            end
            MD_DIVU: begin
                o_is_div = 1'b1;
                o_wr     = ~w_b_zero;
                o_res    = {w_ur, w_uq};
            end
`ifdef MULDIV_MADD_EN
            MD_MADD:  o_res = w_base + w_prod_s;
            MD_MADDU: o_res = w_base + w_prod_u;
            MD_MSUB:  o_res = w_base - w_prod_s;
            MD_MSUBU: o_res = w_base - w_prod_u;
`endif
            default: begin
                o_legal = 1'b0;
                o_wr    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit owning HI/LO: fixed-latency commit of a shadow result.
// Define MULDIV_MADD_EN to enable the madd/maddu/msub/msubu opcodes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  moveto,
    input  logic [1:0]  movefrom,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_res_hi;
    logic [31:0]      r_res_lo;
    logic             r_wr;

    logic             w_legal;
    logic             w_is_div;
    logic             w_wr;
    logic [63:0]      w_res;
    logic             w_issue;
    logic             w_commit;
    logic             w_move_ok;

    muldiv_core u_core (
        .i_op     (md_op),
        .i_a      (A),
        .i_b      (B),
`ifdef MULDIV_MADD_EN
        .i_hi     (r_hi),
        .i_lo     (r_lo),
`endif
        .o_legal  (w_legal),
        .o_is_div (w_is_div),
        .o_wr     (w_wr),
        .o_res    (w_res)
    );

    assign w_issue   = start & ~flush & ~r_busy & w_legal;
    assign w_commit  = r_busy & (r_cnt == CNT_W'(1));
    assign w_move_ok = ~r_busy & ~start & ~flush;

    // Busy flag and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (w_issue) begin
            r_busy <= 1'b1;
            r_cnt  <= w_is_div ? DIV_CNT : MULT_CNT;
        end else if (w_commit) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Shadow result captured at issue; r_wr is low for divide-by-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_wr     <= 1'b0;
        end else if (w_issue) begin
            r_res_hi <= w_res[63:32];
            r_res_lo <= w_res[31:0];
            r_wr     <= w_wr;
        end
    end

    // Architectural HI/LO: commit of the shadow result or an mthi/mtlo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (r_wr) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end else if (w_move_ok) begin
            case (moveto)
                MV_HI:   r_hi <= A;
                MV_LO:   r_lo <= A;
                default: ;
            endcase
        end
    end

    // movefrom mux; during busy this returns the pre-op HI/LO.
    always_comb begin
        md_out = 32'd0;
        case (movefrom)
            MV_HI:   md_out = r_hi;
            MV_LO:   md_out = r_lo;
            default: md_out = 32'd0;
        endcase
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
E-stage multiply/divide unit owning the HI/LO registers. It is the producer side of the mult/div hazard interface.
- Emits `start`/`busy` to the pipeline stall logic.
- Services HI/LO moves (mthi/mtlo/mfhi/mflo) through `moveto`/`movefrom`.
- Models fixed-latency iterative hardware: the result is computed at issue, held in a shadow register, and committed to HI/LO after the configured latency.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..31
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, asynchronous active-low reset
- start, input, 1, issue strobe for the mult/div op in E (single cycle)
- md_op, input, 3, operation code (package constants)
- A, input, 32, forwarded rs operand
- B, input, 32, forwarded rt operand
- moveto, input, 2, 01 = mthi, 10 = mtlo, 00 = none, 11 = illegal (ignored)
- movefrom, input, 2, 01 = mfhi, 10 = mflo, 00 = none
- flush, input, 1, exception/interrupt cancel of the E-stage instruction
- busy, output, 1, operation in flight
- HI, output, 32, architectural HI
- LO, output, 32, architectural LO
- md_out, output, 32, movefrom-selected value

Behaviour:
- Reset (reset==0, async): busy=0, HI=0, LO=0, counter=0, shadow registers=0. md_out is combinational (0 when movefrom=00).
- Issue: accepted on a rising edge when start=1, flush=0, busy=0.
  - Shadow {res_hi,res_lo} is loaded with the full result.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
- Results:
  - mult: signed 32x32 -> 64.
  - multu: unsigned 32x32 -> 64.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - divu: unsigned.
- Count: while busy, counter decrements each cycle. On the edge where counter==1: HI<=res_hi, LO<=res_lo, busy<=0, counter<=0.
- Latency: busy is high for exactly N cycles after the start cycle. New HI/LO are visible in the first cycle busy is low.
- Divide by zero (B==0, div/divu): busy timing is unchanged; HI and LO keep their prior values at commit (no write).
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- moveto: accepted when busy=0, start=0, flush=0. HI or LO <= A at the edge.
- movefrom: md_out = HI (01), LO (10), else 0. Purely combinational, no latency.
- Start while busy: ignored; the in-flight op is unaffected. The stall logic guarantees this never happens legally.
- start and moveto in the same cycle: start wins; moveto is dropped.
- flush with start: the op is not issued; no state changes.
- flush while busy: no effect. The in-flight op is older than the faulting instruction and completes.
- moveto with flush: dropped.
- Reset mid-operation: busy drops immediately; the pending result is discarded.
- Hazard contract: the stall logic stalls D on (busy | start) when the D instruction uses HI/LO. The unit may therefore assume no moveto/movefrom while busy. md_out during busy returns the pre-op HI/LO, and that is the defined behaviour.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: md_op codes 4..7 are legal.
  - madd: {HI,LO} + signed product.
  - maddu: {HI,LO} + unsigned product.
  - msub: {HI,LO} - signed product.
  - msubu: {HI,LO} - unsigned product.
  - 64-bit wrap-around; MULT_CYCLES latency.
  - The accumulator base is {HI,LO} sampled at the issue edge.
- Not defined: codes 4..7 are treated as no-op issues. busy stays 0 and HI/LO are unchanged.

Decomposition:
- Shared package/header:
  - md_op constants: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MADD=4, MD_MADDU=5, MD_MSUB=6, MD_MSUBU=7.
  - moveto/movefrom encodings (MV_NONE=0, MV_HI=1, MV_LO=2).
  - Default cycle counts.
- Sub-module muldiv_core: combinational 64-bit result generator (mult/div/signed/accumulate) feeding the shadow register. The top level holds the counter, busy, HI/LO and move logic.

Test Plan:
- Reset then mult A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA. md_out=LO via movefrom=10.
- divu A=100, B=7 -> busy 10 cycles; HI=2, LO=14. div A=-7, B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- Prior HI=0x11, LO=0x22; div B=0 -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- start with flush=1 (multu 5x5) -> busy stays 0, HI/LO unchanged. Next cycle flush=0 start -> LO=25 after 5 cycles.
- mthi A=0xDEADBEEF, then movefrom=01 -> md_out=0xDEADBEEF same cycle. start+moveto same cycle -> only the op is issued.
- Assert reset at busy cycle 3 of div -> busy=0, HI=LO=0 immediately. With MULDIV_MADD_EN, HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0.
